mem_stage_access: RTL



---
 rtl/mem_stage_access_pkg.sv | 16 +
 rtl/mem_stage_access_mem_wb_reg.sv | 64 ++++++
 rtl/mem_stage_access.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_access_pkg.sv
// Shared pipeline definitions for the MEM stage:
// control-bit positions and the access FSM encoding.
package mem_stage_access_pkg;

  localparam int BRANCH     = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;
  localparam int REG_WRITE  = 1;
  localparam int MEM_TO_REG = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_access_mem_wb_reg.sv
// MEM/WB pipeline register with load, bubble insertion
// and RegWrite suppression for faulted instructions.
module mem_wb_reg
  import mem_stage_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic        kill_rw,
  input  logic [1:0]  wb_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] alu_i,
  input  logic [4:0]  rd_i,
  output logic [1:0]  wb_o,
  output logic [31:0] rdata_o,
  output logic [31:0] alu_o,
  output logic [4:0]  rd_o
);

  logic [1:0]  wb_d, wb_q;
  logic [31:0] rdata_d, rdata_q;
  logic [31:0] alu_d, alu_q;
  logic [4:0]  rd_d, rd_q;

  always_comb begin
    wb_d    = wb_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    if (bubble) begin
      wb_d    = '0;
      rdata_d = '0;
      alu_d   = '0;
      rd_d    = '0;
    end else if (load) begin
      wb_d    = wb_i;
      rdata_d = rdata_i;
      alu_d   = alu_i;
      rd_d    = rd_i;
      if (kill_rw) wb_d[REG_WRITE] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q    <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
    end else begin
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
    end
  end

  assign wb_o    = wb_q;
  assign rdata_o = rdata_q;
  assign alu_o   = alu_q;
  assign rd_o    = rd_q;

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: variable-latency data-memory access over req/ack,
// upstream back-pressure, timeout/misalign error and MEM/WB register.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WB,
  input  logic [2:0]        M,
  input  logic [31:0]       ALURes,
  input  logic [31:0]       DataIn,
  input  logic [4:0]        RdRt,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err,
  output logic [1:0]        WBReg,
  output logic [31:0]       ReadDataReg,
  output logic [31:0]       ALUReg,
  output logic [4:0]        RdRtReg
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              req_d, req_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [31:0]       wdata_d, wdata_q;
  logic              err_d, err_q;

  logic        access, misal, tmo_hit;
  logic        wb_load, wb_bubble, wb_kill, rd_sel;
  logic        stall_c;
  logic [31:0] rdata_in;
  logic        unused_branch;

  assign access  = M[MEM_READ] | M[MEM_WRITE];
  assign misal   = access & (ALURes[1:0] != 2'b00);
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign unused_branch = M[BRANCH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;
    wb_kill   = 1'b0;
    rd_sel    = 1'b0;
    stall_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!access) begin
          wb_load = 1'b1;
        end else if (misal) begin
          wb_load = 1'b1;
          wb_kill = 1'b1;
          err_d   = 1'b1;
        end else begin
          stall_c   = 1'b1;
          state_d   = S_WAIT;
          req_d     = 1'b1;
          we_d      = M[MEM_WRITE];
          addr_d    = ALURes[ADDR_W-1:0];
          wdata_d   = DataIn;
          wb_bubble = 1'b1;
          cnt_d     = '0;
        end
      end
      S_WAIT: begin
        // ack beats the timeout when both land in the same cycle
        if (mem_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          wb_load = 1'b1;
          rd_sel  = ~we_q;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          wb_load = 1'b1;
          wb_kill = 1'b1;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign rdata_in = rd_sel ? mem_rdata : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  mem_wb_reg u_mem_wb (
    .clk     (clk),
    .rst     (rst),
    .load    (wb_load),
    .bubble  (wb_bubble),
    .kill_rw (wb_kill),
    .wb_i    (WB),
    .rdata_i (rdata_in),
    .alu_i   (ALURes),
    .rd_i    (RdRt),
    .wb_o    (WBReg),
    .rdata_o (ReadDataReg),
    .alu_o   (ALUReg),
    .rd_o    (RdRtReg)
  );

  // reset forces stall low even if an access is still on the inputs
  assign stall     = stall_c & ~rst;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;

endmodule
